// File: rtl/ot_wrr_pkt_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ot_arb_pkg : shared types, defaults and helpers for the WRR arbiter   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package ot_arb_pkg;

  localparam int ARB_N_REQ    = 4;
  localparam int ARB_WEIGHT_W = 4;
  localparam int ARB_MAX_REQ  = 8;
  localparam int ARB_MAX_ID_W = 3;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // OR-reduction of set positions; exact for one-hot, 0 for an empty vector
  function automatic logic [ARB_MAX_ID_W-1:0] f_onehot2idx(input logic [ARB_MAX_REQ-1:0] oh);
    logic [ARB_MAX_ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_REQ; i++) begin
      if (oh[i]) idx = idx | ARB_MAX_ID_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ot_wrr_pkt_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ot_wrr_pkt_arbiter_if : requester/grant bundle of the WRR arbiter     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface ot_wrr_pkt_arbiter_if #(
  parameter int N_REQ    = 4,
  parameter int WEIGHT_W = 4,
  parameter int ID_W     = $clog2(N_REQ)
);
  logic [N_REQ-1:0]               req;
  logic [N_REQ-1:0]               last;
  logic [N_REQ-1:0][WEIGHT_W-1:0] weight;
  logic                           ready;
  logic [N_REQ-1:0]               grt;
  logic                           grt_vld;
  logic [ID_W-1:0]                owner;
  logic                           locked;

  modport master (
    output req, last, weight, ready,
    input  grt, grt_vld, owner, locked
  );

  modport slave (
    input  req, last, weight, ready,
    output grt, grt_vld, owner, locked
  );
endinterface
`default_nettype wire

// File: rtl/ot_wrr_pkt_arbiter_pick.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ot_rr_pick : first set bit of vec at or after ptr, wrapping at N_REQ  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module ot_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] vec,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] sel,
  output logic [ID_W-1:0]  sel_idx,
  output logic             any
);

  localparam logic [ID_W:0] c_n = (ID_W+1)'(N_REQ);

  // one extra bit so ptr+k never overflows before the modulo fold
  logic [ID_W:0] w_pos;

  always_comb begin
    sel     = '0;
    sel_idx = '0;
    any     = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_pos = {1'b0, ptr} + (ID_W+1)'(k);
      if (w_pos >= c_n) w_pos = w_pos - c_n;
      if (!any && vec[w_pos[ID_W-1:0]]) begin
        any                   = 1'b1;
        sel[w_pos[ID_W-1:0]]  = 1'b1;
        sel_idx               = w_pos[ID_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ot_wrr_pkt_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ot_wrr_pkt_arbiter : packet-aware weighted round-robin arbiter        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module ot_wrr_pkt_arbiter
  import ot_arb_pkg::*;
#(
  parameter int N_REQ    = ARB_N_REQ,
  parameter int WEIGHT_W = ARB_WEIGHT_W,
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  ot_wrr_pkt_arbiter_if.slave   bus
);

  localparam logic [ID_W-1:0] c_last_idx = ID_W'(N_REQ - 1);

  arb_state_e          r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_owner;
  logic [WEIGHT_W-1:0] r_credit [N_REQ];

  logic [N_REQ-1:0]    w_elig;
  logic [N_REQ-1:0]    w_sel_e;
  logic [N_REQ-1:0]    w_sel_r;
  logic [N_REQ-1:0]    w_lock_oh;
  logic [N_REQ-1:0]    w_grt;
  logic [N_REQ-1:0]    w_grt_q;
  logic [ID_W-1:0]     w_idx_e;
  logic [ID_W-1:0]     w_idx_r;
  logic [ID_W-1:0]     w_cur;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic                w_any_e;
  logic                w_any_r;
  logic                w_reload;
  logic                w_vld;
  logic                w_xfer;
  logic                w_cur_last;
  logic [WEIGHT_W-1:0] w_base       [N_REQ];
  logic [WEIGHT_W-1:0] w_credit_nxt [N_REQ];

  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_elig
      assign w_elig[i] = bus.req[i] & (r_credit[i] != '0);
    end
  endgenerate

  ot_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick_elig (
    .vec     (w_elig),
    .ptr     (r_ptr),
    .sel     (w_sel_e),
    .sel_idx (w_idx_e),
    .any     (w_any_e)
  );

  // fallback pick over raw requests when every requester has run out of credit
  ot_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick_req (
    .vec     (bus.req),
    .ptr     (r_ptr),
    .sel     (w_sel_r),
    .sel_idx (w_idx_r),
    .any     (w_any_r)
  );

  always_comb begin
    w_lock_oh          = '0;
    w_lock_oh[r_owner] = 1'b1;
  end

  assign w_reload = (r_state == ARB_IDLE) & ~w_any_e & w_any_r;

  always_comb begin
    w_grt = w_any_e ? w_sel_e : w_sel_r;
    w_cur = w_any_e ? w_idx_e : w_idx_r;
    if (r_state == ARB_LOCKED) begin
      w_grt = w_lock_oh;
      w_cur = r_owner;
    end
  end

  assign w_grt_q    = rst ? '0 : w_grt;
  assign w_vld      = |(w_grt_q & bus.req);
  assign w_xfer     = w_vld & bus.ready;
  assign w_cur_last = bus.last[w_cur];

  // reload base, then the saturating packet-end decrement of the current owner
  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_credit
      logic [WEIGHT_W-1:0] w_wmax;
      assign w_wmax          = (bus.weight[i] == '0) ? WEIGHT_W'(1) : bus.weight[i];
      assign w_base[i]       = w_reload ? w_wmax : r_credit[i];
      assign w_credit_nxt[i] = (w_cur_last && (w_cur == ID_W'(i)) && (w_base[i] != '0))
                               ? (w_base[i] - WEIGHT_W'(1)) : w_base[i];
    end
  endgenerate

  always_comb begin
    if (w_credit_nxt[w_cur] != '0) begin
      w_ptr_nxt = w_cur;
    end else if (w_cur == c_last_idx) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_cur + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      for (int i = 0; i < N_REQ; i++) r_credit[i] <= '0;
    end else if (w_xfer) begin
      case (r_state)
        ARB_IDLE: begin
          r_owner <= w_cur;
          if (!w_cur_last) r_state <= ARB_LOCKED;
        end
        ARB_LOCKED: begin
          if (w_cur_last) r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
      for (int i = 0; i < N_REQ; i++) r_credit[i] <= w_credit_nxt[i];
      if (w_cur_last) r_ptr <= w_ptr_nxt;
    end
  end

  assign bus.grt     = w_grt_q;
  assign bus.grt_vld = w_vld;
  assign bus.owner   = ID_W'(f_onehot2idx(ARB_MAX_REQ'(w_grt_q)));
  assign bus.locked  = ~rst & (r_state == ARB_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_ot_wrr_pkt_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_ot_wrr_pkt_arbiter : directed + random bench with reference model  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_ot_wrr_pkt_arbiter;

  localparam int N = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  // reference model state
  int   m_locked;
  int   m_owner;
  int   m_ptr;
  int   m_credit [N];

  ot_wrr_pkt_arbiter_if #(.N_REQ(N), .WEIGHT_W(4)) bus ();

  ot_wrr_pkt_arbiter #(.N_REQ(N), .WEIGHT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_owner  = 0;
    m_ptr    = 0;
    for (int i = 0; i < N; i++) m_credit[i] = 0;
  endtask

  // one clock: drive, compare against the model, advance the model
  task automatic cycle(input logic [3:0] rq, input logic [3:0] lt, input logic rd,
                       input logic rs, input logic [15:0] wt);
    int e_idx, e_vld, reload, cand, w;
    logic [3:0] e_grt;
    @(negedge clk);
    bus.req = rq; bus.last = lt; bus.ready = rd; bus.weight = wt; rst = rs;
    #1;
    e_grt = 4'b0; e_idx = 0; reload = 0;
    if (!rs) begin
      if (m_locked != 0) begin
        e_idx = m_owner;
        e_grt = 4'b1 << m_owner;
      end else begin
        cand = 0;
        for (int i = 0; i < N; i++) if (rq[i] && m_credit[i] > 0) cand |= (1 << i);
        if (cand == 0 && rq != 0) begin
          reload = 1;
          cand   = int'(rq);
        end
        for (int k = N - 1; k >= 0; k--) begin
          if (cand[(m_ptr + k) % N]) e_idx = (m_ptr + k) % N;
        end
        if (cand != 0) e_grt = 4'b1 << e_idx;
      end
    end
    e_vld = ((e_grt & rq) != 0) ? 1 : 0;
    chk("grt",     32'(bus.grt),     32'(e_grt));
    chk("grt_vld", 32'(bus.grt_vld), 32'(e_vld));
    chk("owner",   32'(bus.owner),   (e_grt != 0) ? 32'(e_idx) : 32'd0);
    chk("locked",  32'(bus.locked),  32'((m_locked != 0) && !rs));
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else if (e_vld != 0 && rd) begin
      if (reload != 0) begin
        for (int i = 0; i < N; i++) begin
          w = int'((wt >> (4 * i)) & 16'hF);
          m_credit[i] = (w == 0) ? 1 : w;
        end
      end
      if (lt[e_idx]) begin
        if (m_credit[e_idx] > 0) m_credit[e_idx]--;
        m_ptr    = (m_credit[e_idx] > 0) ? e_idx : (e_idx + 1) % N;
        m_locked = 0;
      end else begin
        m_locked = 1;
        m_owner  = e_idx;
      end
    end
  endtask

  initial begin
    logic [3:0]  rq, lt;
    logic [15:0] wt;
    logic        rd, rs;
    n_vec = 0;
    n_err = 0;
    model_reset();
    bus.req = '0; bus.last = '0; bus.ready = 1'b0; bus.weight = '0; rst = 1'b1;

    // reset holds every output low even with requests present
    cycle(4'b1111, 4'b1111, 1'b1, 1'b1, 16'h1111);
    cycle(4'b1111, 4'b1111, 1'b1, 1'b1, 16'h1111);

    // single-beat fairness, weight 1 everywhere
    for (int k = 0; k < 8; k++) begin
      cycle(4'b1111, 4'b1111, 1'b1, 1'b0, 16'h1111);
      chk("rr_seq", 32'(bus.owner), 32'(k % N));
    end

    // 3-beat packet from requester 0 against constant requester 1
    cycle(4'b0000, 4'b0000, 1'b1, 1'b1, 16'h1111);
    cycle(4'b0011, 4'b0000, 1'b1, 1'b0, 16'h1111);
    cycle(4'b0011, 4'b0000, 1'b1, 1'b0, 16'h1111);
    chk("lock_beat2", 32'(bus.grt), 32'h1);
    cycle(4'b0011, 4'b0011, 1'b1, 1'b0, 16'h1111);
    cycle(4'b0011, 4'b0011, 1'b1, 1'b0, 16'h1111);
    chk("lock_next", 32'(bus.grt), 32'h2);

    // weights: index 3 gets three packets per round
    cycle(4'b0000, 4'b0000, 1'b1, 1'b1, 16'h3111);
    for (int k = 0; k < 18; k++) cycle(4'b1111, 4'b1111, 1'b1, 1'b0, 16'h3111);

    // back-pressure and owner drop while locked to requester 2
    cycle(4'b0000, 4'b0000, 1'b1, 1'b1, 16'h1111);
    cycle(4'b0100, 4'b0000, 1'b1, 1'b0, 16'h1111);
    for (int k = 0; k < 5; k++) cycle(4'b1111, 4'b0000, 1'b0, 1'b0, 16'h1111);
    for (int k = 0; k < 2; k++) begin
      cycle(4'b1011, 4'b0000, 1'b1, 1'b0, 16'h1111);
      chk("drop_hold", 32'(bus.grt), 32'h4);
    end
    cycle(4'b1111, 4'b0100, 1'b1, 1'b0, 16'h1111);

    // reset while locked, then first pick starts from index 0
    cycle(4'b0001, 4'b0000, 1'b1, 1'b0, 16'h1111);
    cycle(4'b0001, 4'b0000, 1'b1, 1'b1, 16'h1111);
    cycle(4'b0110, 4'b0110, 1'b1, 1'b0, 16'h1111);
    chk("rst_first", 32'(bus.grt), 32'h2);

    // weight 0 acts as 1; weight[0] raised mid-round applies after reload
    cycle(4'b0000, 4'b0000, 1'b1, 1'b1, 16'h1101);
    for (int k = 0; k < 3; k++) cycle(4'b1111, 4'b1111, 1'b1, 1'b0, 16'h1101);
    for (int k = 0; k < 12; k++) cycle(4'b1111, 4'b1111, 1'b1, 1'b0, 16'h1102);

    // randomized traffic
    wt = 16'h1111;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        rq[i] = ($urandom_range(0, 9) < 7);
        lt[i] = ($urandom_range(0, 9) < 4);
      end
      rd = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) wt = 16'($urandom_range(0, 16'hFFFF)) & 16'h3333;
      cycle(rq, lt, rd, rs, wt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
